// File: rtl/fdma_wr_arbiter4_pkg.sv
// Shared types and helpers for the four-channel FDMA write arbiter.
package fdma_wr_arbiter4_pkg;

  localparam int NCH_FIXED = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_ZACK = 2'd3
  } arb_state_e;

  // Round-robin pointer advance; a 2-bit add wraps 3 -> 0 on its own.
  function automatic logic [1:0] next_ptr(input logic [1:0] g);
    return g + 2'd1;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/fdma_wr_arbiter4_rr_pick4.sv
// Rotating priority picker: first set request at or after ptr, wrapping mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;
  logic       found;

  // Scan upward from ptr and keep the first requester encountered.
  always_comb begin
    idx   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fdma_wr_arbiter4.sv
// Four-to-one round-robin arbiter in front of the single FDMA write master.
// One burst is forwarded at a time; busy/valid strobes go back to the granted
// writer only, and a watchdog abandons bursts on a hung master.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no burst in flight; requests sampled and a winner latched
// REQ   | fdma_wareq held high, waiting for the master to report busy
// BUSY  | master moving the burst; strobes routed to the granted writer
// ZACK  | zero-length request: one-cycle busy pulse, master never touched
module fdma_wr_arbiter4
  import fdma_wr_arbiter4_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_ADDR_WIDTH = 23,
  parameter int          NCH            = 4,
  parameter int unsigned TMO_CYCLES     = 4096
) (
  input  logic                          ui_clk,
  input  logic                          ui_rst,
  input  logic [NCH*AXI_ADDR_WIDTH-1:0] s_waddr,
  input  logic [NCH-1:0]                s_wareq,
  input  logic [NCH*16-1:0]             s_wsize,
  output logic [NCH-1:0]                s_wbusy,
  input  logic [NCH*AXI_DATA_WIDTH-1:0] s_wdata,
  output logic [NCH-1:0]                s_wvalid,
  output logic [AXI_ADDR_WIDTH-1:0]     fdma_waddr,
  output logic                          fdma_wareq,
  output logic [15:0]                   fdma_wsize,
  input  logic                          fdma_wbusy,
  output logic [AXI_DATA_WIDTH-1:0]     fdma_wdata,
  input  logic                          fdma_wvalid,
  output logic [1:0]                    grant_o,
  output logic                          err_tmo,
  output logic                          err_zero
);

  // Counter must be able to hold TMO_CYCLES-1; it saturates at all-ones.
  localparam int          WD_W    = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);
  localparam int unsigned TMO_LIM = (TMO_CYCLES == 0) ? 0 : TMO_CYCLES - 1;
  localparam logic [WD_W-1:0] TMO_LIM_V = TMO_LIM[WD_W-1:0];

  arb_state_e                state_q,    state_d;
  logic [1:0]                rr_ptr_q,   rr_ptr_d;
  logic [1:0]                grant_q,    grant_d;
  logic                      wareq_q,    wareq_d;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q,    waddr_d;
  logic [15:0]               wsize_q,    wsize_d;
  logic [WD_W-1:0]           wdog_q,     wdog_d;
  logic                      err_tmo_q,  err_tmo_d;
  logic                      err_zero_q, err_zero_d;

  logic [1:0]                pick_idx;
  logic                      pick_any;
  logic [AXI_ADDR_WIDTH-1:0] cand_addr;
  logic [15:0]               cand_size;
  logic                      wdog_hit;

  rr_pick4 u_pick (
    .req (s_wareq[3:0]),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign cand_addr = s_waddr[int'(pick_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
  assign cand_size = s_wsize[int'(pick_idx)*16 +: 16];
  assign wdog_hit  = (TMO_CYCLES != 0) && (wdog_q >= TMO_LIM_V);

  // Next-state logic: arbitration in IDLE, handshake and abandon paths elsewhere.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    wareq_d    = wareq_q;
    waddr_d    = waddr_q;
    wsize_d    = wsize_q;
    err_tmo_d  = err_tmo_q;
    err_zero_d = err_zero_q;
    unique case (state_q)
      ST_IDLE: begin
        wareq_d = 1'b0;
        if (pick_any) begin
          grant_d = pick_idx;
          waddr_d = cand_addr;
          wsize_d = cand_size;
          if (cand_size != 16'd0) begin
            wareq_d = 1'b1;
            state_d = ST_REQ;
          end else begin
            err_zero_d = 1'b1;
            state_d    = ST_ZACK;
          end
        end
      end
      ST_ZACK: begin
        state_d  = ST_IDLE;
        rr_ptr_d = next_ptr(grant_q);
      end
      ST_REQ: begin
        if (fdma_wbusy) begin
          wareq_d = 1'b0;
          state_d = ST_BUSY;
        end else if (!s_wareq[grant_q]) begin
          wareq_d  = 1'b0;
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr(grant_q);
        end else if (wdog_hit) begin
          err_tmo_d = 1'b1;
          wareq_d   = 1'b0;
          state_d   = ST_IDLE;
          rr_ptr_d  = next_ptr(grant_q);
        end
      end
      ST_BUSY: begin
        if (!fdma_wbusy) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr(grant_q);
        end else if (wdog_hit) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
          rr_ptr_d  = next_ptr(grant_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Watchdog: restarts on any state change, counts REQ/BUSY cycles, saturates.
  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if ((state_q == ST_REQ || state_q == ST_BUSY) && (wdog_q != '1)) begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  // Strobe routing back to the granted writer; everyone else sees zero.
  always_comb begin
    s_wbusy  = '0;
    s_wvalid = '0;
    unique case (state_q)
      ST_REQ, ST_BUSY: begin
        s_wbusy  = onehot4(grant_q) & {4{fdma_wbusy}};
        s_wvalid = onehot4(grant_q) & {4{fdma_wvalid}};
      end
      ST_ZACK: s_wbusy = onehot4(grant_q);
      default: ;
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      grant_q    <= 2'd0;
      wareq_q    <= 1'b0;
      waddr_q    <= '0;
      wsize_q    <= 16'd0;
      wdog_q     <= '0;
      err_tmo_q  <= 1'b0;
      err_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      wareq_q    <= wareq_d;
      waddr_q    <= waddr_d;
      wsize_q    <= wsize_d;
      wdog_q     <= wdog_d;
      err_tmo_q  <= err_tmo_d;
      err_zero_q <= err_zero_d;
    end
  end

  assign fdma_wdata = s_wdata[int'(grant_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign fdma_waddr = waddr_q;
  assign fdma_wareq = wareq_q;
  assign fdma_wsize = wsize_q;
  assign grant_o    = grant_q;
  assign err_tmo    = err_tmo_q;
  assign err_zero   = err_zero_q;

endmodule
